// File: rtl/rr_sched_pkg.sv
// Shared types and helpers for the round-robin grant scheduler.
package rr_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Number of requesters served for a given grant-index width.
    function automatic int num_req(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage

// File: rtl/decoder_param.sv
// Binary-to-one-hot decoder with an active-high enable; all outputs low when disabled.
module decoder_param #(
    parameter int INPUT_WIDTH = 2
) (
    input  logic                          enable,
    input  logic [INPUT_WIDTH-1:0]        data_in,
    output logic [(1<<INPUT_WIDTH)-1:0]   data_out
);

    // Set exactly one output bit selected by data_in when enabled.
    always_comb begin
        data_out = '0;
        if (enable) begin
            data_out[data_in] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr, wrapping mod N.
module rr_pick
    import rr_sched_pkg::*;
#(
    parameter int INPUT_WIDTH = 2
) (
    input  logic [num_req(INPUT_WIDTH)-1:0] req,
    input  logic [INPUT_WIDTH-1:0]          ptr,
    output logic                            found,
    output logic [INPUT_WIDTH-1:0]          idx
);

    localparam int N = num_req(INPUT_WIDTH);

    logic [INPUT_WIDTH-1:0] cand;

    // Walk candidates ptr, ptr+1, ... (natural INPUT_WIDTH-bit wrap) and keep the first hit.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + k[INPUT_WIDTH-1:0];
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/rr_grant_scheduler.sv
// Transaction-based round-robin scheduler driving a one-hot resource select.
// A grant is held until the owner pulses done; the pointer then rotates past the owner.
// Optional feature macro: RR_SCHED_TIMEOUT_EN forces release after MAX_HOLD grant cycles.
module rr_grant_scheduler
    import rr_sched_pkg::*;
#(
    parameter int INPUT_WIDTH = 2,
    parameter int MAX_HOLD    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [num_req(INPUT_WIDTH)-1:0] req,
    input  logic                            done,
    output logic [num_req(INPUT_WIDTH)-1:0] grant,
    output logic [INPUT_WIDTH-1:0]          grant_idx,
    output logic                            busy,
    output logic                            timeout
);

    if (MAX_HOLD < 1) begin : g_bad_max_hold
        $error("rr_grant_scheduler: MAX_HOLD must be at least 1");
    end

    state_t                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] ptr_q, ptr_d;
    logic [INPUT_WIDTH-1:0] idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   pick_found;
    logic [INPUT_WIDTH-1:0] pick_idx;
    logic                   release_now;

`ifdef RR_SCHED_TIMEOUT_EN
    localparam int CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             expire;
`endif

    rr_pick #(
        .INPUT_WIDTH (INPUT_WIDTH)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state logic: pick a new owner in IDLE, hold it in GRANT until released.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        release_now = 1'b0;
`ifdef RR_SCHED_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
        expire      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (enable && pick_found) begin
                    state_d = GRANT;
                    idx_d   = pick_idx;
                    busy_d  = 1'b1;
`ifdef RR_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
`ifdef RR_SCHED_TIMEOUT_EN
                // The current cycle is the MAX_HOLD-th grant cycle when the count reads MAX_HOLD-1.
                expire      = (cnt_q == CNT_W'(MAX_HOLD - 1));
                release_now = done || expire;
                timeout_d   = expire && !done;
                cnt_d       = cnt_q + 1'b1;
`else
                release_now = done;
`endif
                if (release_now) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset overrides any transaction in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

`ifdef RR_SCHED_TIMEOUT_EN
    // Hold counter and forced-release pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    decoder_param #(
        .INPUT_WIDTH (INPUT_WIDTH)
    ) u_decoder (
        .enable   (busy_q),
        .data_in  (idx_q),
        .data_out (grant)
    );

    assign grant_idx = idx_q;
    assign busy      = busy_q;

endmodule

// File: doc/rr_grant_scheduler.md
# rr_grant_scheduler

Round-robin scheduler that shares one downstream resource between 2**INPUT_WIDTH requesters and drives its one-hot select lines. The winning index is registered and expanded to a one-hot grant through `decoder_param`, so the grant bus plugs directly into any decoder/demux-style select network. Grants are transaction-based: a grant is held until the owner signals `done`, then the priority pointer rotates past the last winner.

## Interface
- INPUT_WIDTH, 2: width of grant index; N = 2**INPUT_WIDTH requesters.
- MAX_HOLD, 16: maximum grant length in cycles (used only with RR_SCHED_TIMEOUT_EN); must be ≥1.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  permits new grants; does not revoke a held grant.
- req  input  N  request vector, bit i = requester i.
- done  input  1  current owner releases the resource (single-cycle pulse).
- grant  output  N  one-hot grant, all-zero when idle.
- grant_idx  output  INPUT_WIDTH  binary index of current owner; holds last value when idle.
- busy  output  1  high while a grant is held.
- timeout  output  1  one-cycle pulse on forced release (RR_SCHED_TIMEOUT_EN only; tied 0 otherwise).

## Operation
- States: IDLE, GRANT.
- IDLE: if enable=1 and req≠0, pick first set req bit scanning ptr, ptr+1, … wrapping mod N; load grant_idx, go GRANT. Otherwise stay.
- GRANT: grant = decoded grant_idx, busy=1. On done=1: go IDLE, ptr ← (grant_idx+1) mod N.
- done in IDLE ignored. Owner dropping req while in GRANT does not release; only done (or timeout) releases.
- enable=0 in GRANT has no effect on the held grant; blocks the next pick in IDLE.
- req changes in GRANT are not sampled until back in IDLE.
- Reset values: state=IDLE, ptr=0, grant=0, grant_idx=0, busy=0, timeout=0.
- Pointer arithmetic is INPUT_WIDTH-bit unsigned, natural wrap at N-1 → 0.

## Timing
- All outputs registered.
- Request-to-grant: req/enable sampled in IDLE at edge k → grant, busy valid after edge k (visible cycle k+1).
- done sampled at edge k → grant=0, busy=0 after edge k; earliest next grant after edge k+1 (one idle bubble cycle between owners, always).
- rst sampled at any edge overrides everything, including a grant mid-transaction; no done required.
- Simultaneous done and rst: rst wins, ptr=0.

## Configuration
- RR_SCHED_TIMEOUT_EN defined: hold counter clears on entering GRANT, increments each GRANT cycle; when it reaches MAX_HOLD without done, release as if done, ptr advances past owner, timeout pulses for one cycle coincident with busy falling. done on the same cycle as expiry counts as normal release (timeout=0).
- Not defined: no counter, no MAX_HOLD logic; grant held indefinitely until done; timeout tied 0.

## Structure
- Package rr_sched_pkg: state enum typedef (IDLE, GRANT), helper function for N from INPUT_WIDTH.
- Sub-module rr_pick: combinational rotate-priority picker (req, ptr → found, idx).
- One-hot grant produced by existing `decoder_param` instance (INPUT_WIDTH matched, enable=busy).

## Test plan (INPUT_WIDTH=2)
- Reset: hold rst 2 cycles with req=1111 → grant=0000, grant_idx=00, busy=0 throughout and on first cycle after release.
- Skip: ptr=0, req=0101, enable=1 → grant=0001; pulse done → one cycle grant=0000, then grant=0100.
- Fairness/wrap: req=1111 constant, done one cycle after each grant → grant sequence 0001, 0010, 0100, 1000, 0001 with one zero cycle between each.
- Enable: enable=0, req=0010 for 5 cycles → grant=0000; enable=1 → grant=0010; drop enable and req → grant stays 0010 until done.
- Reset mid-grant: owner 3 (grant=1000), assert rst → grant=0000 next cycle; release, req=1001 → grant=0001 (ptr back to 0).
- Timeout (RR_SCHED_TIMEOUT_EN, MAX_HOLD=4): req=0010, no done → grant=0010 for 4 cycles, then grant=0000 with timeout=1 for one cycle; without macro grant holds 0010 for 20+ cycles.
